cpu_debug_ctrl: RTL and testbench

Run/halt/single-step controller and debug-view selector for the single-cycle RV32I core on the lab board. It debounces the four board keys and produces a one-cycle CPU enable pulse (free-running divided rate, or manual single step). It steps the debug register address through x0..x31 and registers the 32-bit value that the seven-segment display shows (PC, selected register, or current instruction). It replaces the fixed a0/PC key mux and the separate slow clock with a single-clock-domain enable scheme.

---
 rtl/cpu_debug_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cpu_debug_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_ctrl.sv
// Run/halt/single-step controller and debug-view selector for the RV32I core.
// Debounces board keys, emits a one-cycle cpu_en pulse, picks the display value.
//
// Ports:
//   clk, rst            system clock, async active-high reset
//   key[3:0]            raw keys: run/halt, step, next reg, next view
//   pc, instr, reg_data CPU values that can be shown on the display
//   reg_addr            debug register address driven to the CPU
//   cpu_en              registered one-cycle CPU clock-enable pulse
//   halted              high whenever the controller is not running
//   view                one-hot display view: PC, REG, INSTR
//   number              registered value for the seven-segment display
//   step_count          number of cpu_en pulses since reset (wraps)
module cpu_debug_ctrl #(
  parameter int w_data          = 32,
  parameter int w_reg_addr      = 5,
  parameter int default_reg     = 10,
  parameter int debounce_cycles = 500000,
  parameter int run_div         = 50000000,
  parameter int start_running   = 1,
  parameter int w_step          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            key,
  input  logic [w_data-1:0]     pc,
  input  logic [w_data-1:0]     instr,
  input  logic [w_data-1:0]     reg_data,
  output logic [w_reg_addr-1:0] reg_addr,
  output logic                  cpu_en,
  output logic                  halted,
  output logic [2:0]            view,
  output logic [w_data-1:0]     number,
  output logic [w_step-1:0]     step_count
);

  localparam int w_db  = $clog2(debounce_cycles);
  localparam int w_div = $clog2(run_div);

  localparam logic [w_db-1:0]  db_last  = w_db'(debounce_cycles - 1);
  localparam logic [w_div-1:0] div_last = w_div'(run_div - 1);

  typedef enum logic [1:0] {
    s_run,
    s_halt,
    s_step
  } state_t;

  localparam state_t reset_state =
    (start_running != 0) ? s_run : s_halt;

  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      db;
  logic [3:0]      db_q;
  logic [w_db-1:0] db_cnt [4];
  logic [3:0]      press;

  state_t          state;
  logic [w_div-1:0] div;

  // One-cycle pulse on each accepted rising edge of a debounced key.
  assign press = db & ~db_q;

  // Synchroniser plus per-key debounce: a new level is accepted only
  // after it has been seen continuously for debounce_cycles cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == db_last) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + w_db'(1);
        end
      end
    end
  end

  // Run/halt/step sequencer. The divider idles at zero outside RUN so
  // a resumed run always waits a full period before its first pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= reset_state;
      halted     <= (start_running == 0);
      cpu_en     <= 1'b0;
      div        <= '0;
      step_count <= '0;
    end else begin
      cpu_en <= 1'b0;
      div    <= '0;
      if (cpu_en) begin
        step_count <= step_count + w_step'(1);
      end
      case (state)
        s_run: begin
          if (press[0]) begin
            state  <= s_halt;
            halted <= 1'b1;
          end else if (div == div_last) begin
            cpu_en <= 1'b1;
          end else begin
            div <= div + w_div'(1);
          end
        end
        s_halt: begin
          if (press[0]) begin
            state  <= s_run;
            halted <= 1'b0;
          end else if (press[1]) begin
            state  <= s_step;
            cpu_en <= 1'b1;
          end
        end
        s_step: begin
          state <= s_halt;
        end
        default: begin
          state  <= s_halt;
          halted <= 1'b1;
        end
      endcase
    end
  end

  // Register / view selection and the display register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_addr <= w_reg_addr'(default_reg);
      view     <= 3'b001;
      number   <= '0;
    end else begin
      if (press[2]) begin
        reg_addr <= reg_addr + w_reg_addr'(1);
      end
      if (press[3]) begin
        view <= {view[1:0], view[2]};
      end
      unique case (1'b1)
        view[0]: number <= pc;
        view[1]: number <= reg_data;
        view[2]: number <= instr;
        default: number <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Testbench for cpu_debug_ctrl: directed scenarios plus randomized keys
// checked against a window-based debounce / arithmetic run-period model.
module tb_cpu_debug_ctrl;

  localparam int D = 4;
  localparam int R = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_b = 1'b0;
  logic [3:0]  key = '0;
  logic [3:0]  key_b = '0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic [31:0] reg_data = '0;

  logic [4:0]  reg_addr, reg_addr_b;
  logic        cpu_en, cpu_en_b;
  logic        halted, halted_b;
  logic [2:0]  view, view_b;
  logic [31:0] number, number_b;
  logic [15:0] step_count, step_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_debug_ctrl #(
    .w_data(32), .w_reg_addr(5), .default_reg(10),
    .debounce_cycles(D), .run_div(R),
    .start_running(1), .w_step(16)
  ) dut (
    .clk(clk), .rst(rst), .key(key),
    .pc(pc), .instr(instr), .reg_data(reg_data),
    .reg_addr(reg_addr), .cpu_en(cpu_en), .halted(halted),
    .view(view), .number(number), .step_count(step_count)
  );

  cpu_debug_ctrl #(
    .w_data(32), .w_reg_addr(5), .default_reg(10),
    .debounce_cycles(D), .run_div(R),
    .start_running(0), .w_step(16)
  ) dut_b (
    .clk(clk), .rst(rst_b), .key(key_b),
    .pc(pc), .instr(instr), .reg_data(reg_data),
    .reg_addr(reg_addr_b), .cpu_en(cpu_en_b), .halted(halted_b),
    .view(view_b), .number(number_b), .step_count(step_count_b)
  );

  // Reference model state (for dut only).
  int          n;
  logic [3:0]  rawh[$];
  logic [3:0]  m_db, m_db_prev;
  logic        m_running, m_stepping, m_en;
  int          run_start, m_steps, m_addr, m_view;
  logic [31:0] m_number;

  function automatic logic [3:0] synced(int j);
    if (j >= 3) return rawh[j-3];
    return 4'b0000;
  endfunction

  function automatic logic [31:0] view_val(int v);
    if (v == 0) return pc;
    if (v == 1) return reg_data;
    return instr;
  endfunction

  task automatic model_reset();
    n = 0;
    rawh.delete();
    m_db = '0;
    m_db_prev = '0;
    m_running = 1'b1;
    m_stepping = 1'b0;
    m_en = 1'b0;
    run_start = 0;
    m_steps = 0;
    m_addr = 10;
    m_view = 0;
    m_number = '0;
  endtask

  // Advance one clock and update the model from the inputs sampled there.
  task automatic tick();
    logic [3:0] pr;
    logic       new_en;
    logic       all_diff;
    pr = m_db & ~m_db_prev;
    @(posedge clk);
    n++;
    rawh.push_back(key);
    m_number = view_val(m_view);
    if (m_en) m_steps++;
    new_en = 1'b0;
    if (m_stepping) begin
      m_stepping = 1'b0;
    end else if (m_running) begin
      if (pr[0]) m_running = 1'b0;
      else if ((n - run_start) % R == 0) new_en = 1'b1;
    end else begin
      if (pr[0]) begin
        m_running = 1'b1;
        run_start = n;
      end else if (pr[1]) begin
        m_stepping = 1'b1;
        new_en = 1'b1;
      end
    end
    m_en = new_en;
    if (pr[2]) m_addr = (m_addr + 1) % 32;
    if (pr[3]) m_view = (m_view + 1) % 3;
    m_db_prev = m_db;
    for (int k = 0; k < 4; k++) begin
      if (n >= D) begin
        all_diff = 1'b1;
        for (int j = n - D + 1; j <= n; j++) begin
          if (synced(j)[k] == m_db[k]) all_diff = 1'b0;
        end
        if (all_diff) m_db[k] = ~m_db[k];
      end
    end
    #1;
  endtask

  task automatic hold_key(int k, int hold, int rest);
    key[k] = 1'b1;
    repeat (hold) tick();
    key[k] = 1'b0;
    repeat (rest) tick();
  endtask

  task automatic do_reset();
    key = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    int pulses;
    int last;
    int gap_bad;
    pulses = 0;
    last = -1;
    gap_bad = 0;
    do_reset();
    checks++;
    if (reg_addr !== 5'd10 || view !== 3'b001 || halted !== 1'b0 ||
        cpu_en !== 1'b0 || number !== 32'd0 || step_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got addr=%0d view=%b halted=%b en=%b num=%h sc=%0d want 10 001 0 0 0 0",
               reg_addr, view, halted, cpu_en, number, step_count);
    end
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (cpu_en) begin
        if (last < 0 && i != R) gap_bad++;
        if (last >= 0 && i - last != R) gap_bad++;
        last = i;
        pulses++;
      end
    end
    checks++;
    if (gap_bad != 0 || pulses != 3) begin
      errors++;
      $display("FAIL run_period: got pulses=%0d bad_gaps=%0d want 3 0", pulses, gap_bad);
    end
    checks++;
    if (step_count !== 16'd3) begin
      errors++;
      $display("FAIL run_step_count: got %0d want 3", step_count);
    end
  endtask

  task automatic test_halt_step();
    int t;
    int en_after;
    int steps;
    int tr;
    int te;
    logic [15:0] sc0;
    t = 0;
    en_after = 0;
    steps = 0;
    tr = 0;
    te = 0;
    key[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (halted && t == 0) t = i;
      if (t != 0 && cpu_en) en_after++;
    end
    key[0] = 1'b0;
    repeat (10) begin
      tick();
      if (cpu_en) en_after++;
    end
    checks++;
    if (t < 1 || t > 7) begin
      errors++;
      $display("FAIL halt_latency: got %0d cycles want 1..7", t);
    end
    checks++;
    if (en_after != 0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_quiet: got pulses=%0d halted=%b want 0 1", en_after, halted);
    end
    sc0 = step_count;
    key[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 7) key[1] = 1'b0;
      tick();
      if (cpu_en) steps++;
    end
    checks++;
    if (steps != 1 || step_count !== sc0 + 16'd1 || halted !== 1'b1) begin
      errors++;
      $display("FAIL single_step: got pulses=%0d sc=%0d halted=%b want 1 %0d 1",
               steps, step_count, halted, sc0 + 16'd1);
    end
    key[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 7) key[0] = 1'b0;
      tick();
      if (!halted && tr == 0) tr = i;
      if (cpu_en && te == 0) te = i;
    end
    checks++;
    if (tr == 0 || te - tr != R) begin
      errors++;
      $display("FAIL resume_first_pulse: got %0d cycles want %0d", te - tr, R);
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    logic [15:0] sc0;
    pulses = 0;
    hold_key(0, 6, 10);
    sc0 = step_count;
    key[0] = 1'b1;
    key[1] = 1'b1;
    repeat (6) tick();
    key = '0;
    repeat (4) begin
      tick();
      if (cpu_en) pulses++;
    end
    checks++;
    if (halted !== 1'b0 || pulses != 0 || step_count !== sc0) begin
      errors++;
      $display("FAIL run_beats_step: got halted=%b pulses=%0d sc=%0d want 0 0 %0d",
               halted, pulses, step_count, sc0);
    end
  endtask

  task automatic test_glitch_regwrap();
    int pulses;
    logic wrapped;
    logic [4:0] prev;
    pulses = 0;
    wrapped = 1'b0;
    hold_key(0, 6, 10);
    key[1] = 1'b1;
    repeat (3) tick();
    key[1] = 1'b0;
    repeat (12) begin
      tick();
      if (cpu_en) pulses++;
    end
    checks++;
    if (pulses != 0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL glitch_ignored: got pulses=%0d halted=%b want 0 1", pulses, halted);
    end
    do_reset();
    for (int i = 0; i < 22; i++) begin
      prev = reg_addr;
      hold_key(2, 5, 5);
      if (prev == 5'd31 && reg_addr == 5'd0) wrapped = 1'b1;
    end
    checks++;
    if (reg_addr !== 5'd0 || !wrapped) begin
      errors++;
      $display("FAIL reg_wrap: got addr=%0d wrapped=%b want 0 1", reg_addr, wrapped);
    end
  endtask

  task automatic test_view();
    int waited;
    waited = 0;
    pc = 32'h0000_0010;
    reg_data = 32'hDEAD_BEEF;
    instr = 32'h0050_0093;
    key[3] = 1'b1;
    while (view !== 3'b010 && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    checks++;
    if (view !== 3'b010 || number !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL view_reg: got view=%b num=%h want 010 deadbeef", view, number);
    end
    key[3] = 1'b0;
    repeat (8) tick();
    hold_key(3, 5, 5);
    checks++;
    if (view !== 3'b100 || number !== 32'h0050_0093) begin
      errors++;
      $display("FAIL view_instr: got view=%b num=%h want 100 00500093", view, number);
    end
    hold_key(3, 5, 5);
    checks++;
    if (view !== 3'b001 || number !== 32'h0000_0010) begin
      errors++;
      $display("FAIL view_pc: got view=%b num=%h want 001 00000010", view, number);
    end
    pc = 32'h0000_0044;
    checks++;
    if (number !== 32'h0000_0010) begin
      errors++;
      $display("FAIL number_hold: got %h want 00000010", number);
    end
    tick();
    checks++;
    if (number !== 32'h0000_0044) begin
      errors++;
      $display("FAIL number_latency: got %h want 00000044", number);
    end
  endtask

  task automatic test_random();
    logic [2:0] ev;
    do_reset();
    for (int i = 0; i < 900; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 4) == 0) key[k] = ~key[k];
      end
      pc = $urandom;
      instr = $urandom;
      reg_data = $urandom;
      tick();
      ev = 3'b001 << m_view;
      checks++;
      if (cpu_en !== m_en || halted !== ~m_running ||
          reg_addr !== 5'(m_addr) || view !== ev ||
          number !== m_number || step_count !== 16'(m_steps)) begin
        errors++;
        $display("FAIL random_cycle%0d: got en=%b h=%b a=%0d v=%b n=%h sc=%0d want %b %b %0d %b %h %0d",
                 i, cpu_en, halted, reg_addr, view, number, step_count,
                 m_en, ~m_running, m_addr % 32, ev, m_number, m_steps % 65536);
      end
    end
    key = '0;
  endtask

  task automatic test_reset_mid_step();
    int waited;
    int pulses;
    logic hung;
    waited = 0;
    pulses = 0;
    hung = 1'b0;
    do_reset();
    hold_key(0, 6, 10);
    key[1] = 1'b1;
    while (cpu_en !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (cpu_en !== 1'b1) begin
      errors++;
      hung = 1'b1;
      $display("FAIL step_pulse_timeout: got en=%b want 1", cpu_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_en !== 1'b0 || halted !== 1'b0 || reg_addr !== 5'd10 ||
        view !== 3'b001 || number !== 32'd0 || step_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_step: got en=%b h=%b a=%0d v=%b n=%h sc=%0d want 0 0 10 001 0 0",
               cpu_en, halted, reg_addr, view, number, step_count);
    end
    key = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    if (hung) return;
    rst_b = 1'b0;
    key_b[1] = 1'b1;
    waited = 0;
    while (cpu_en_b !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (cpu_en_b !== 1'b1 || halted_b !== 1'b1) begin
      errors++;
      $display("FAIL halted_start_step: got en=%b h=%b want 1 1", cpu_en_b, halted_b);
    end
    rst_b = 1'b1;
    #1;
    checks++;
    if (cpu_en_b !== 1'b0 || halted_b !== 1'b1 || reg_addr_b !== 5'd10 ||
        view_b !== 3'b001 || number_b !== 32'd0 || step_count_b !== 16'd0) begin
      errors++;
      $display("FAIL reset_b_mid_step: got en=%b h=%b a=%0d v=%b n=%h sc=%0d want 0 1 10 001 0 0",
               cpu_en_b, halted_b, reg_addr_b, view_b, number_b, step_count_b);
    end
    key_b = '0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    repeat (40) begin
      tick();
      if (cpu_en_b || !halted_b) pulses++;
    end
    checks++;
    if (pulses != 0 || step_count_b !== 16'd0) begin
      errors++;
      $display("FAIL halted_start_idle: got bad_cycles=%0d sc=%0d want 0 0", pulses, step_count_b);
    end
  endtask

  initial begin
    rst_b = 1'b1;
    model_reset();
    test_reset();
    test_halt_step();
    test_simultaneous();
    test_glitch_regwrap();
    test_view();
    test_random();
    test_reset_mid_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
